// File: rtl/rr_bus_arbiter4_pkg.sv
// Shared definitions for the 4-source round-robin bus arbiter.
//   state_t      : arbiter FSM encoding (IDLE / BUSY)
//   SRC_A..SRC_D : source index constants, matching the sel encoding
//   DATA_W_DEF   : default width of each source bus
//   rr_pick()    : round-robin search returning {found, index}
package rr_bus_arbiter4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    localparam int DATA_W_DEF = 16;

    // First set bit of mask, searching upward from start and wrapping mod 4.
    // The loop runs from the farthest offset down so the nearest hit is the
    // last one written and therefore wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux16_4to1.sv
// 4:1 data select for the shared bus. Purely combinational.
//   sel          : in  2       source index (0 = sig_a .. 3 = sig_d)
//   sig_a..sig_d : in  DATA_W  source buses
//   bus_out      : out DATA_W  selected source
module mux16_4to1
    import rr_bus_arbiter4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] sig_a,
    input  logic [DATA_W-1:0] sig_b,
    input  logic [DATA_W-1:0] sig_c,
    input  logic [DATA_W-1:0] sig_d,
    output logic [DATA_W-1:0] bus_out
);

    always_comb begin
        bus_out = sig_a;
        case (sel)
            SRC_A: bus_out = sig_a;
            SRC_B: bus_out = sig_b;
            SRC_C: bus_out = sig_c;
            SRC_D: bus_out = sig_d;
            default: bus_out = sig_a;
        endcase
    end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin arbiter for a shared 4:1 bus with req/grant/done handshake and
// a hold limit that stops one owner from starving the others.
//   clk, rst     : in  clock, synchronous active-high reset
//   req          : in  4       request per source
//   done         : in  4       release strobe; only the owner's bit counts
//   sig_a..sig_d : in  DATA_W  source data
//   grant        : out 4       registered one-hot grant, zero when idle
//   sel          : out 2       encoded owner index (holds its value when idle)
//   bus_out      : out DATA_W  source selected by sel (combinational)
//   bus_valid    : out 1       grant is non-zero
//   hold_cnt     : out CNT_W   cycles held by current owner minus 1
module rr_bus_arbiter4
    import rr_bus_arbiter4_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [3:0]        done,
    input  logic [DATA_W-1:0] sig_a,
    input  logic [DATA_W-1:0] sig_b,
    input  logic [DATA_W-1:0] sig_c,
    input  logic [DATA_W-1:0] sig_d,
    output logic [3:0]        grant,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid,
    output logic [CNT_W-1:0]  hold_cnt
);

    state_t           state_reg, state_next;
    logic [3:0]       grant_reg, grant_next;
    logic [1:0]       sel_reg, sel_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic [CNT_W-1:0] hold_reg, hold_next;

    logic [3:0] owner_mask;
    logic [3:0] others;
    logic       own_req;
    logic       own_done;
    logic       hold_expired;
    logic       release_now;
    logic [2:0] pick_idle;
    logic [2:0] pick_hand;

    // Mask of the current owner, decoded from sel (valid only while BUSY).
    for (genvar gi = 0; gi < 4; gi++) begin : g_owner
        assign owner_mask[gi] = (sel_reg == 2'(gi));
    end

    assign others       = req & ~owner_mask;
    assign own_req      = |(req & owner_mask);
    assign own_done     = |(done & owner_mask);
    assign hold_expired = (hold_reg == CNT_W'(MAX_HOLD - 1));
    // done, dropped request and hold expiry may coincide; any of them is one release.
    assign release_now  = own_done | ~own_req | (hold_expired & (|others));

    assign pick_idle = rr_pick(req, ptr_reg);
    // After a release the pointer moves to owner+1, so the handover search
    // starts there; the owner is excluded and would come last anyway.
    assign pick_hand = rr_pick(others, sel_reg + 2'd1);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_next = BUSY;
                    sel_next   = pick_idle[1:0];
                    grant_next = 4'b0001 << pick_idle[1:0];
                    hold_next  = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_next = sel_reg + 2'd1;
                    if (pick_hand[2]) begin
                        sel_next   = pick_hand[1:0];
                        grant_next = 4'b0001 << pick_hand[1:0];
                        hold_next  = '0;
                    end else if (own_req) begin
                        // Sole requester re-granted: grant and sel unchanged.
                        hold_next = '0;
                    end else begin
                        state_next = IDLE;
                        grant_next = 4'b0000;
                        hold_next  = '0;
                    end
                end else if (hold_reg != CNT_W'(MAX_HOLD)) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= 4'b0000;
            sel_reg   <= SRC_A;
            ptr_reg   <= 2'd0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
        end
    end

    mux16_4to1 #(.DATA_W(DATA_W)) u_mux (
        .sel     (sel_reg),
        .sig_a   (sig_a),
        .sig_b   (sig_b),
        .sig_c   (sig_c),
        .sig_d   (sig_d),
        .bus_out (bus_out)
    );

    assign grant     = grant_reg;
    assign sel       = sel_reg;
    assign bus_valid = |grant_reg;
    assign hold_cnt  = hold_reg;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
module tb_rr_bus_arbiter4;

    localparam int DATA_W   = 16;
    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 8;

    logic              clk;
    logic              rst;
    logic [3:0]        req;
    logic [3:0]        done;
    logic [DATA_W-1:0] sig_a, sig_b, sig_c, sig_d;
    logic [3:0]        grant;
    logic [1:0]        sel;
    logic [DATA_W-1:0] bus_out;
    logic              bus_valid;
    logic [CNT_W-1:0]  hold_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Behavioural model: who owns the bus (-1 = nobody), last owner index,
    // rotation pointer, and how many cycles the owner has held minus 1.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    rr_bus_arbiter4 #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .sig_a     (sig_a),
        .sig_b     (sig_b),
        .sig_c     (sig_c),
        .sig_d     (sig_d),
        .grant     (grant),
        .sel       (sel),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int search(input logic [3:0] mask, input int start);
        for (int k = 0; k < 4; k++) begin
            if (mask[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Model advances on each rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        logic [3:0] oth;
        bit rel;
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = search(req, m_ptr);
                m_last  = m_owner;
                m_held  = 0;
            end
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            rel = done[m_owner] || !req[m_owner] || (m_held == MAX_HOLD - 1 && oth != 4'b0000);
            if (rel) begin
                m_ptr  = (m_owner + 1) % 4;
                m_held = 0;
                if (oth != 4'b0000) begin
                    m_owner = search(oth, m_ptr);
                    m_last  = m_owner;
                end else if (!req[m_owner]) begin
                    m_owner = -1;
                end
            end else if (m_held < MAX_HOLD) begin
                m_held = m_held + 1;
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_bus;
        if (chk_en) begin
            case (m_last)
                0: exp_bus = sig_a;
                1: exp_bus = sig_b;
                2: exp_bus = sig_c;
                default: exp_bus = sig_d;
            endcase
            cmp("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            cmp("sel", 32'(sel), 32'(m_last));
            cmp("bus_out", 32'(bus_out), 32'(exp_bus));
            cmp("bus_valid", 32'(bus_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
            cmp("hold_cnt", 32'(hold_cnt), 32'(m_held));
        end
    end

    // Advance to just after the next falling edge, after the compare process.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] rot [5];

    initial begin
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100;
        rot[3] = 4'b1000; rot[4] = 4'b0001;
        rst = 1'b1; req = 4'b1111; done = 4'b0000;
        sig_a = 16'hAAAA; sig_b = 16'hBBBB; sig_c = 16'hCCCC; sig_d = 16'hDDDD;
        @(posedge clk);
        #1 chk_en = 1'b1;
        step();
        cmp("lit_reset_grant", 32'(grant), 32'h0);
        cmp("lit_reset_valid", 32'(bus_valid), 32'h0);
        rst = 1'b0;
        step();
        cmp("lit_first_grant", 32'(grant), 32'h1);
        cmp("lit_first_sel", 32'(sel), 32'h0);
        cmp("lit_first_bus", 32'(bus_out), 32'hAAAA);
        cmp("lit_first_valid", 32'(bus_valid), 32'h1);

        // Rotation: each owner signals done in the second cycle of its slot.
        for (int k = 0; k < 4; k++) begin
            cmp("lit_rot_a", 32'(grant), 32'(rot[k]));
            done = 4'b0000;
            step();
            cmp("lit_rot_b", 32'(grant), 32'(rot[k]));
            done = rot[k];
            step();
        end
        cmp("lit_rot_wrap", 32'(grant), 32'(rot[4]));

        // Hold limit: source 0 keeps the bus exactly MAX_HOLD cycles.
        done = 4'b0000; req = 4'b0011;
        for (int i = 0; i < MAX_HOLD; i++) begin
            cmp("lit_hold_cnt", 32'(hold_cnt), 32'(i));
            cmp("lit_hold_grant", 32'(grant), 32'h1);
            step();
        end
        cmp("lit_hold_handover", 32'(grant), 32'h2);
        cmp("lit_hold_reset_cnt", 32'(hold_cnt), 32'h0);

        // Sole requester: source 2 keeps the bus, counter saturates.
        req = 4'b0100;
        step();
        cmp("lit_sole_grant", 32'(grant), 32'h4);
        for (int i = 0; i < 20; i++) begin
            step();
            cmp("lit_sole_keep", 32'(grant), 32'h4);
        end
        cmp("lit_sole_sat", 32'(hold_cnt), 32'(MAX_HOLD));

        // Stray done from a non-owner is ignored.
        done = 4'b1000;
        step();
        cmp("lit_stray_grant", 32'(grant), 32'h4);
        cmp("lit_stray_hold", 32'(hold_cnt), 32'(MAX_HOLD));
        done = 4'b0000;

        // Hand over to source 1, then source 1 drops its request.
        req = 4'b0010;
        step();
        cmp("lit_drop_owner1", 32'(grant), 32'h2);
        req = 4'b0000;
        step();
        cmp("lit_drop_grant", 32'(grant), 32'h0);
        cmp("lit_drop_valid", 32'(bus_valid), 32'h0);
        cmp("lit_drop_sel_hold", 32'(sel), 32'h1);
        cmp("lit_drop_bus", 32'(bus_out), 32'hBBBB);

        // Reset mid-operation clears everything including the pointer.
        req = 4'b0100;
        step();
        cmp("lit_mid_grant", 32'(grant), 32'h4);
        rst = 1'b1;
        step();
        cmp("lit_mid_rst_grant", 32'(grant), 32'h0);
        cmp("lit_mid_rst_hold", 32'(hold_cnt), 32'h0);
        rst = 1'b0; req = 4'b1111;
        step();
        cmp("lit_mid_ptr0", 32'(grant), 32'h1);

        // Randomised phase: sticky requests so hold expiry is exercised too.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            done  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            sig_a = 16'($urandom); sig_b = 16'($urandom);
            sig_c = 16'($urandom); sig_d = 16'($urandom);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter4.md
Name: rr_bus_arbiter4

Overview:
Round-robin arbiter that shares the 16-bit 4:1 operand/result bus among four requesters. It owns the 2-bit select of the bus mux and sequences ownership with a req/grant/done handshake. A hold limit stops a long requester from starving the others. Sits between the datapath sources and any shared 16-bit consumer, e.g. the register-file write port or a debug/memory port.

Parameters:
DATA_W, 16, width of each source bus and of bus_out
MAX_HOLD, 8, maximum consecutive cycles one owner keeps the bus while others are waiting (range 1..255)
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req  in  4  request per source; bit i = source i
done  in  4  owner releases bus; only the bit of the current owner is honoured
sig_a  in  DATA_W  source 0 data
sig_b  in  DATA_W  source 1 data
sig_c  in  DATA_W  source 2 data
sig_d  in  DATA_W  source 3 data
grant  out  4  one-hot grant, registered; all-zero when idle
sel  out  2  encoded owner index driving the mux
bus_out  out  DATA_W  selected source data (combinational from sel and the sources)
bus_valid  out  1  high when grant is non-zero
hold_cnt  out  CNT_W  cycles the current owner has held the bus, minus 1

Behaviour:
- Reset: grant=0, sel=0, bus_valid=0, hold_cnt=0, priority pointer=0, state=IDLE. Reset mid-transfer clears everything at the same edge. No release cycle is emitted.
- States: IDLE, BUSY.
- IDLE, any req set at edge N: grant goes to the first set bit, searching from the pointer upward mod 4. grant, sel and bus_valid are valid after edge N. This gives 1-cycle request-to-grant latency. State goes to BUSY and hold_cnt=0.
- BUSY, each edge: hold_cnt increments and saturates at MAX_HOLD.
- BUSY, release condition at an edge: owner's done=1, OR owner's req=0, OR (hold_cnt==MAX_HOLD-1 AND any other req set).
- On release the pointer becomes owner+1 mod 4.
  - If any req other than the owner's is set, the new winner is granted at the same edge. This is a back-to-back handover with no bubble, and hold_cnt=0.
  - If the owner's own req is still set and no one else requests, the owner is re-granted and hold_cnt=0.
  - Otherwise the block goes to IDLE with grant=0.
- No release and no other requesters: the owner keeps the bus indefinitely. hold_cnt saturates and is never preempted.
- done bits of non-owners are ignored. done while IDLE is ignored.
- Simultaneous done and hold expiry count as a single release.
- grant is always one-hot or zero, and sel always equals the encoded grant. When idle, sel holds its last value and bus_out follows it, but bus_valid=0.
- bus_out is a pure combinational select: sel=0→sig_a, 1→sig_b, 2→sig_c, 3→sig_d. It has no register stage.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, BUSY=1'b1), the SRC_A..SRC_D index constants (0..3), and DATA_W default 16.
- One natural sub-module: mux16_4to1, the 16-bit 4:1 data select driven by sel. All sequencing logic (FSM, pointer, hold counter, round-robin search) stays in rr_bus_arbiter4.

Test Plan:
- Reset with req=4'b1111 held: after rst drops, first edge gives grant=0001, sel=0, bus_out=sig_a (0xAAAA), bus_valid=1.
- Rotation: req=1111, each owner asserts done one cycle after grant. Grant sequence is 0001,0010,0100,1000,0001 on consecutive 2-cycle slots with no idle cycle.
- Hold limit: req=0011, source 0 never asserts done, MAX_HOLD=8. Source 0 holds exactly 8 cycles (hold_cnt 0..7), then grant=0010 on the next edge.
- Sole requester: req=0100 only, no done for 20 cycles. grant stays 0100, hold_cnt saturates at 8, no idle gap.
- Request drop and stray done: owner 1 deasserts req → IDLE next edge with grant=0000 and bus_valid=0. A done=1000 pulse while source 2 owns the bus has no effect.
- Reset mid-op: rst pulsed while grant=0100. Next edge gives grant=0000 and hold_cnt=0; with req=1111 afterwards, the first grant is 0001 (pointer reset to 0).
